video_capture: RTL

VIDEO_CAPTURE -- requirements
Module: video_capture

---
 rtl/video_capture.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/video_capture.sv
// Captures 8-bit RGB332 pixels from a slow pixel-clock video stream into a byte-wide memory port
// once the input timing has been stable for P_lock_frames frames; writes appear one I_clock after the pixel tick.
module video_capture #(
  parameter logic [15:0] P_capture_base = 16'h0000,
  parameter logic [15:0] P_active_h     = 16'd256,
  parameter logic [15:0] P_active_v     = 16'd240,
  parameter logic [3:0]  P_lock_frames  = 4'd2
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_vid_clock,
  input  logic        I_vid_blank,
  input  logic        I_vid_hsync,
  input  logic        I_vid_vsync,
  input  logic [7:0]  I_vid_red,
  input  logic [7:0]  I_vid_green,
  input  logic [7:0]  I_vid_blue,
  output logic        O_mem_clock,
  output logic [15:0] O_mem_addr,
  output logic [7:0]  O_mem_data,
  output logic        O_mem_write,
  output logic        O_locked,
  output logic        O_error,
  output logic [15:0] O_line_ticks,
  output logic [15:0] O_frame_lines
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [3:0]  good_cnt, good_cnt_nxt;
  logic        vclk_q, hs_q, vs_q;
  logic [15:0] h_ticks, x, y, line_cnt, ref_len;
  logic        ref_vld, ref_pend, x_sat;
  logic        tick, hs_start, vs_start;
  logic [15:0] x_cur, y_line, y_cur, lc_line;
  logic        line_viol, frame_viol, viol, wr_en;
  logic        unused_bits;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign O_mem_clock = I_clock;
  assign O_locked    = (state == LOCKED);
  assign unused_bits = ^{I_vid_red[4:0], I_vid_green[5:0], I_vid_blue[4:0]};

  assign tick     = I_vid_clock & ~vclk_q;
  assign hs_start = tick & hs_q & ~I_vid_hsync;
  assign vs_start = tick & vs_q & ~I_vid_vsync;

  // Line processing happens first, so a coincident vsync sees the y/line count of the closing line.
  assign x_cur   = hs_start ? 16'd0 : x;
  assign y_line  = (hs_start && x != 16'd0) ? sat_inc(y) : y;
  assign y_cur   = vs_start ? 16'd0 : y_line;
  assign lc_line = hs_start ? sat_inc(line_cnt) : line_cnt;

  assign line_viol  = hs_start &&
                      ((x != 16'd0 && x != P_active_h) || x_sat ||
                       (ref_vld && h_ticks != ref_len));
  assign frame_viol = vs_start && (y_line != P_active_v);
  assign viol       = (state != SEARCH) && (line_viol || frame_viol);

  assign wr_en = tick && I_vid_blank && (x_cur < P_active_h) && (y_cur < P_active_v) &&
                 (state == LOCKED) && !viol;

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    if (viol) begin
      state_nxt    = SEARCH;
      good_cnt_nxt = 4'd0;
    end else if (vs_start) begin
      case (state)
        SEARCH:  state_nxt = MEASURE;
        MEASURE: begin
          good_cnt_nxt = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
          if (good_cnt_nxt >= P_lock_frames)
            state_nxt = LOCKED;
        end
        LOCKED:  state_nxt = LOCKED;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state    <= SEARCH;
      good_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      vclk_q        <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_ticks       <= 16'd0;
      x             <= 16'd0;
      y             <= 16'd0;
      line_cnt      <= 16'd0;
      ref_len       <= 16'd0;
      ref_vld       <= 1'b0;
      ref_pend      <= 1'b0;
      x_sat         <= 1'b0;
      O_mem_write   <= 1'b0;
      O_mem_addr    <= 16'd0;
      O_mem_data    <= 8'd0;
      O_error       <= 1'b0;
      O_line_ticks  <= 16'd0;
      O_frame_lines <= 16'd0;
    end else begin
      vclk_q      <= I_vid_clock;
      O_mem_write <= wr_en;
      O_error     <= viol;
      if (wr_en) begin
        O_mem_addr <= P_capture_base + {y_cur[7:0], x_cur[7:0]};
        O_mem_data <= {I_vid_red[7:5], I_vid_green[7:6], I_vid_blue[7:5]};
      end
      if (tick) begin
        hs_q    <= I_vid_hsync;
        vs_q    <= I_vid_vsync;
        h_ticks <= hs_start ? 16'd1 : sat_inc(h_ticks);
        if (hs_start)
          O_line_ticks <= h_ticks;
        x     <= I_vid_blank ? sat_inc(x_cur) : x_cur;
        x_sat <= (hs_start ? 1'b0 : x_sat) | (I_vid_blank && x_cur == 16'hFFFF);
        y     <= y_cur;
        if (vs_start) begin
          O_frame_lines <= lc_line;
          line_cnt      <= 16'd0;
        end else begin
          line_cnt <= lc_line;
        end
        // Reference length comes from the first full line after entering MEASURE.
        if (viol) begin
          ref_vld  <= 1'b0;
          ref_pend <= 1'b0;
        end else begin
          if (hs_start && ref_pend) begin
            ref_len  <= h_ticks;
            ref_vld  <= 1'b1;
            ref_pend <= 1'b0;
          end
          if (vs_start && state == SEARCH)
            ref_pend <= 1'b1;
        end
      end
    end
  end

endmodule
